// File: rtl/wb_shared_bus_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect: bus FSM states and a
// constant-foldable log2 helper used to size grant indices and the watchdog counter.
package wb_shared_bus_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } bus_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin request picker: one-hot grant for the first requester after last_grant.
// Latency: combinational. Backpressure: none, the caller registers the result.
// Grant is all-zero when no request is present.
module wb_rr_arbiter
    import wb_shared_bus_pkg::*;
#(
    parameter int NM  = 3,
    parameter int LGW = (NM > 1) ? clog2(NM) : 1
) (
    input  logic [NM-1:0]  req,
    input  logic [LGW-1:0] last_grant,
    output logic [NM-1:0]  grant
);

    logic [NM-1:0] hi;
    logic [NM-1:0] lo;

    // Scanning downward leaves the lowest qualifying index in each half.
    always_comb begin
        hi = '0;
        lo = '0;
        for (int m = NM - 1; m >= 0; m--) begin
            if (req[m] && (LGW'(m) > last_grant)) begin
                hi    = '0;
                hi[m] = 1'b1;
            end
            if (req[m] && (LGW'(m) <= last_grant)) begin
                lo    = '0;
                lo[m] = 1'b1;
            end
        end
        grant = (|hi) ? hi : lo;
    end

endmodule

// File: rtl/wb_shared_bus.sv
// N-master/M-slave Wishbone classic shared bus with round-robin arbitration, mask/base decode,
// unmapped-address error responder and watchdog. Latency: 1 cycle arbitration, data path combinational.
// Backpressure: masters stall on their own stb until ack/err; one idle bubble between bus owners.
module wb_shared_bus
    import wb_shared_bus_pkg::*;
#(
    parameter int NM = 3,
    parameter int NS = 5,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [NS*AW-1:0] SLAVE_BASE = {32'h30FF_FD00, 32'h30FF_FE00, 32'h30FF_FF00,
                                               32'h3000_1000, 32'h3000_0000},
    parameter logic [NS*AW-1:0] SLAVE_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00,
                                               32'hFFFF_F000, 32'hFFFF_F000},
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NM*AW-1:0]     i_m_adr,
    input  logic [NM*DW-1:0]     i_m_dat,
    input  logic [NM*DW/8-1:0]   i_m_sel,
    input  logic [NM-1:0]        i_m_we,
    input  logic [NM-1:0]        i_m_cyc,
    input  logic [NM-1:0]        i_m_stb,
    output logic [DW-1:0]        o_m_dat,
    output logic [NM-1:0]        o_m_ack,
    output logic [NM-1:0]        o_m_err,
    output logic [AW-1:0]        o_s_adr,
    output logic [DW-1:0]        o_s_dat,
    output logic [DW/8-1:0]      o_s_sel,
    output logic                 o_s_we,
    output logic [NS-1:0]        o_s_cyc,
    output logic [NS-1:0]        o_s_stb,
    input  logic [NS*DW-1:0]     i_s_dat,
    input  logic [NS-1:0]        i_s_ack,
    output logic [NM-1:0]        o_grant,
    output logic                 o_timeout
);

    localparam int SW  = DW / 8;
    localparam int LGW = (NM > 1) ? clog2(NM) : 1;
    localparam int SIW = (NS > 1) ? clog2(NS) : 1;
    localparam int CW  = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    bus_state_t     state_q, state_d;
    logic [NM-1:0]  grant_q, grant_d;
    logic [LGW-1:0] gidx_q, gidx_d;
    logic [LGW-1:0] last_q, last_d;
    logic [CW-1:0]  wd_q, wd_d;
    logic           err_q, err_d;

    logic [NM-1:0]  arb_grant;
    logic [LGW-1:0] arb_idx;

    logic [AW-1:0]  adr_g;
    logic [DW-1:0]  dat_g;
    logic [SW-1:0]  sel_g;
    logic           we_g, cyc_g, stb_g;
    logic           granted, active;
    logic           hit_any;
    logic [SIW-1:0] sidx;
    logic [NS-1:0]  s_onehot;
    logic           s_ack_sel;
    logic [DW-1:0]  s_dat_sel;
    logic           wd_fire, err_out;

    wb_rr_arbiter #(.NM(NM), .LGW(LGW)) u_arb (
        .req        (i_m_cyc),
        .last_grant (last_q),
        .grant      (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int m = 0; m < NM; m++) begin
            if (arb_grant[m]) arb_idx = LGW'(m);
        end
    end

    // Granted master's request, selected by the registered index.
    always_comb begin
        adr_g = '0;
        dat_g = '0;
        sel_g = '0;
        we_g  = 1'b0;
        cyc_g = 1'b0;
        stb_g = 1'b0;
        for (int m = 0; m < NM; m++) begin
            if (gidx_q == LGW'(m)) begin
                adr_g = i_m_adr[m*AW +: AW];
                dat_g = i_m_dat[m*DW +: DW];
                sel_g = i_m_sel[m*SW +: SW];
                we_g  = i_m_we[m];
                cyc_g = i_m_cyc[m];
                stb_g = i_m_stb[m];
            end
        end
    end

    // Lowest-numbered matching slave wins on overlapping windows.
    always_comb begin
        hit_any  = 1'b0;
        sidx     = '0;
        s_onehot = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if ((adr_g & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                hit_any     = 1'b1;
                sidx        = SIW'(k);
                s_onehot    = '0;
                s_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        s_ack_sel = 1'b0;
        s_dat_sel = '0;
        for (int k = 0; k < NS; k++) begin
            if (sidx == SIW'(k)) begin
                s_ack_sel = i_s_ack[k];
                s_dat_sel = i_s_dat[k*DW +: DW];
            end
        end
    end

    assign granted = (state_q == GRANTED);
    assign active  = granted && cyc_g && stb_g;
    // A slave ack in the expiry cycle takes precedence over the watchdog.
    assign wd_fire = (TIMEOUT != 0) && active && hit_any && !s_ack_sel
                     && (wd_q == CW'(TIMEOUT - 1));
    assign err_out = granted && (err_q || wd_fire);

    assign o_grant   = grant_q;
    assign o_m_ack   = (granted && hit_any && s_ack_sel) ? grant_q : '0;
    assign o_m_err   = err_out ? grant_q : '0;
    assign o_m_dat   = (granted && hit_any) ? s_dat_sel : '0;
    assign o_s_adr   = granted ? adr_g : '0;
    assign o_s_dat   = granted ? dat_g : '0;
    assign o_s_sel   = granted ? sel_g : '0;
    assign o_s_we    = granted && we_g;
    assign o_s_cyc   = (granted && cyc_g && !err_out) ? s_onehot : '0;
    assign o_s_stb   = (active && !err_out) ? s_onehot : '0;
    assign o_timeout = wd_fire;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|i_m_cyc) begin
                    state_d = GRANTED;
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                    last_d  = arb_idx;
                end
            end
            GRANTED: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        err_d = active && !hit_any && !err_q;
        if ((TIMEOUT == 0) || !active || !hit_any || s_ack_sel || err_out)
            wd_d = '0;
        else
            wd_d = wd_q + CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LGW'(NM - 1);
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus: directed bus scenarios followed by randomized multi-master rounds
// checked against a transaction-level model of arbitration order, decode and response timing.
module tb_wb_shared_bus;

    localparam int NM = 3;
    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                i_clk = 1'b0;
    logic                i_reset = 1'b1;
    logic [NM*AW-1:0]    m_adr = '0;
    logic [NM*DW-1:0]    m_dat = '0;
    logic [NM*DW/8-1:0]  m_sel = '0;
    logic [NM-1:0]       m_we  = '0;
    logic [NM-1:0]       m_cyc = '0;
    logic [NM-1:0]       m_stb = '0;
    logic [DW-1:0]       o_m_dat;
    logic [NM-1:0]       o_m_ack;
    logic [NM-1:0]       o_m_err;
    logic [AW-1:0]       o_s_adr;
    logic [DW-1:0]       o_s_dat;
    logic [DW/8-1:0]     o_s_sel;
    logic                o_s_we;
    logic [NS-1:0]       o_s_cyc;
    logic [NS-1:0]       o_s_stb;
    logic [NS*DW-1:0]    s_dat = '0;
    logic [NS-1:0]       s_ack = '0;
    logic [NM-1:0]       o_grant;
    logic                o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave address windows as the SoC map sees them.
    int unsigned sbase [NS] = '{32'h3000_0000, 32'h3000_1000, 32'h30FF_FF00, 32'h30FF_FE00, 32'h30FF_FD00};
    int unsigned ssize [NS] = '{32'h1000, 32'h1000, 32'h100, 32'h100, 32'h100};

    always #5 i_clk = ~i_clk;

    wb_shared_bus #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_m_adr   (m_adr),
        .i_m_dat   (m_dat),
        .i_m_sel   (m_sel),
        .i_m_we    (m_we),
        .i_m_cyc   (m_cyc),
        .i_m_stb   (m_stb),
        .o_m_dat   (o_m_dat),
        .o_m_ack   (o_m_ack),
        .o_m_err   (o_m_err),
        .o_s_adr   (o_s_adr),
        .o_s_dat   (o_s_dat),
        .o_s_sel   (o_s_sel),
        .o_s_we    (o_s_we),
        .o_s_cyc   (o_s_cyc),
        .o_s_stb   (o_s_stb),
        .i_s_dat   (s_dat),
        .i_s_ack   (s_ack),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic [31:0] adr);
        m_cyc[m]          = cyc;
        m_stb[m]          = stb;
        m_we[m]           = 1'($urandom_range(0, 1));
        m_adr[m*AW +: AW] = adr;
        m_dat[m*DW +: DW] = $urandom();
        m_sel[m*4 +: 4]   = 4'hF;
    endtask

    task automatic idle_all();
        m_cyc = '0;
        m_stb = '0;
        s_ack = '0;
    endtask

    task automatic do_reset();
        idle_all();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic release_bus();
        idle_all();
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int last;
        logic [NM-1:0] req;
        int tgt [NM];
        int lat [NM];
        int w, outcome;
        bit found;
        logic [31:0] adr;

        // Reset state
        do_reset();
        settle();
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_s_cyc", 32'(o_s_cyc), 32'h0);
        chk("rst_m_ack", 32'(o_m_ack), 32'h0);
        chk("rst_m_err", 32'(o_m_err), 32'h0);
        chk("rst_timeout", 32'(o_timeout), 32'h0);
        chk("rst_s_adr", o_s_adr, 32'h0);

        // 1: master 0 reads slave 3, ack three cycles after stb
        set_m(0, 1, 1, 32'h30FF_FE00);
        settle();
        chk("t1_grant_arb", 32'(o_grant), 32'h0);
        tick(); settle();
        chk("t1_grant", 32'(o_grant), 32'b001);
        chk("t1_s_cyc", 32'(o_s_cyc), 32'b01000);
        chk("t1_s_stb", 32'(o_s_stb), 32'b01000);
        chk("t1_s_adr", o_s_adr, 32'h30FF_FE00);
        chk("t1_ack_w1", 32'(o_m_ack), 32'h0);
        tick(); settle();
        chk("t1_ack_w2", 32'(o_m_ack), 32'h0);
        tick(); settle();
        chk("t1_ack_w3", 32'(o_m_ack), 32'h0);
        tick();
        s_ack[3] = 1'b1;
        s_dat[3*DW +: DW] = 32'hDEAD_BEEF;
        settle();
        chk("t1_ack", 32'(o_m_ack), 32'b001);
        chk("t1_dat", o_m_dat, 32'hDEAD_BEEF);
        chk("t1_err", 32'(o_m_err), 32'h0);
        tick();
        idle_all();
        settle();
        chk("t1_s_cyc_drop", 32'(o_s_cyc), 32'h0);
        tick(); settle();
        chk("t1_grant_free", 32'(o_grant), 32'h0);

        // 2: round-robin between masters 0 and 1
        do_reset();
        set_m(0, 1, 0, 32'h3000_0000);
        set_m(1, 1, 0, 32'h3000_0000);
        tick(); settle();
        chk("t2_first", 32'(o_grant), 32'b001);
        tick();
        set_m(0, 0, 0, 32'h3000_0000);
        settle();
        chk("t2_drop_cycle", 32'(o_grant), 32'b001);
        tick(); settle();
        chk("t2_bubble", 32'(o_grant), 32'h0);
        tick(); settle();
        chk("t2_second", 32'(o_grant), 32'b010);
        tick();
        set_m(1, 0, 0, 32'h3000_0000);
        tick();
        set_m(0, 1, 0, 32'h3000_0000);
        set_m(1, 1, 0, 32'h3000_0000);
        tick(); settle();
        chk("t2_rr_wrap", 32'(o_grant), 32'b001);
        release_bus();

        // 3: master 1 writes an unmapped address
        set_m(1, 1, 1, 32'h4000_0000);
        tick(); settle();
        chk("t3_grant", 32'(o_grant), 32'b010);
        chk("t3_s_cyc_a", 32'(o_s_cyc), 32'h0);
        chk("t3_err_a", 32'(o_m_err), 32'h0);
        tick(); settle();
        chk("t3_err", 32'(o_m_err), 32'b010);
        chk("t3_ack", 32'(o_m_ack), 32'h0);
        chk("t3_s_cyc_b", 32'(o_s_cyc), 32'h0);
        tick(); settle();
        chk("t3_err_gap", 32'(o_m_err), 32'h0);
        tick(); settle();
        chk("t3_err_again", 32'(o_m_err), 32'b010);
        release_bus();

        // 4: watchdog on a silent RAM access
        set_m(0, 1, 1, 32'h3000_1004);
        tick();
        for (int c = 1; c < TO; c++) begin
            settle();
            chk("t4_wait_err", 32'(o_m_err), 32'h0);
            chk("t4_wait_to", 32'(o_timeout), 32'h0);
            chk("t4_wait_stb", 32'(o_s_stb), 32'b00010);
            tick();
        end
        settle();
        chk("t4_err", 32'(o_m_err), 32'b001);
        chk("t4_timeout", 32'(o_timeout), 32'h1);
        chk("t4_stb_off", 32'(o_s_stb), 32'h0);
        chk("t4_cyc_off", 32'(o_s_cyc), 32'h0);
        tick(); settle();
        chk("t4_after_err", 32'(o_m_err), 32'h0);
        chk("t4_after_to", 32'(o_timeout), 32'h0);
        chk("t4_after_stb", 32'(o_s_stb), 32'b00010);
        release_bus();

        // 5: master 0 locks the bus over two transfers while master 2 waits
        set_m(0, 1, 1, 32'h3000_0010);
        tick();
        set_m(2, 1, 1, 32'h3000_0000);
        s_ack[0] = 1'b1;
        settle();
        chk("t5_ack1", 32'(o_m_ack), 32'b001);
        chk("t5_grant1", 32'(o_grant), 32'b001);
        tick();
        s_ack = '0;
        m_stb[0] = 1'b0;
        settle();
        chk("t5_hold", 32'(o_grant), 32'b001);
        tick();
        m_stb[0] = 1'b1;
        s_ack[0] = 1'b1;
        settle();
        chk("t5_ack2", 32'(o_m_ack), 32'b001);
        chk("t5_grant2", 32'(o_grant), 32'b001);
        tick();
        s_ack = '0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        settle();
        chk("t5_drop", 32'(o_grant), 32'b001);
        tick(); settle();
        chk("t5_bubble", 32'(o_grant), 32'h0);
        tick(); settle();
        chk("t5_m2", 32'(o_grant), 32'b100);
        release_bus();

        // 6: reset while master 0 waits for slave 3
        set_m(0, 1, 1, 32'h30FF_FE00);
        tick(); settle();
        chk("t6_grant", 32'(o_grant), 32'b001);
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        idle_all();
        s_ack[3] = 1'b1;
        settle();
        chk("t6_grant_rst", 32'(o_grant), 32'h0);
        chk("t6_s_cyc_rst", 32'(o_s_cyc), 32'h0);
        chk("t6_to_rst", 32'(o_timeout), 32'h0);
        chk("t6_late_ack", 32'(o_m_ack), 32'h0);
        release_bus();

        // Randomized rounds against a transaction-level model
        last = NM - 1;
        for (int r = 0; r < 30; r++) begin
            req = NM'($urandom_range(1, (1 << NM) - 1));
            for (int m = 0; m < NM; m++) begin
                tgt[m] = -1;
                lat[m] = 0;
                if (req[m]) begin
                    tgt[m] = $urandom_range(0, NS);
                    if (tgt[m] == NS) begin
                        tgt[m] = -1;
                        adr = 32'h4000_0000 | $urandom_range(0, 32'hFFFF);
                    end else begin
                        adr = sbase[tgt[m]] + ($urandom_range(0, ssize[tgt[m]] - 1) & ~32'h3);
                    end
                    lat[m] = $urandom_range(0, 9);
                    set_m(m, 1, 1, adr);
                end
            end
            while (req != '0) begin
                found = 1'b0;
                w = 0;
                for (int i = 1; i <= NM; i++) begin
                    int c;
                    c = (last + i) % NM;
                    if (req[c] && !found) begin
                        w = c;
                        found = 1'b1;
                    end
                end
                settle();
                chk("rnd_idle", 32'(o_grant), 32'h0);
                if (tgt[w] < 0) outcome = 2;
                else if (lat[w] + 1 <= TO) outcome = lat[w] + 1;
                else outcome = TO;
                tick();
                for (int j = 1; j <= outcome; j++) begin
                    if (j > 1) tick();
                    s_ack = NS'($urandom());
                    for (int k = 0; k < NS; k++) s_dat[k*DW +: DW] = $urandom();
                    if (tgt[w] >= 0) s_ack[tgt[w]] = (j == lat[w] + 1);
                    settle();
                    if (j == 1) chk("rnd_grant", 32'(o_grant), 32'(1 << w));
                    if (j < outcome) begin
                        chk("rnd_ack_wait", 32'(o_m_ack), 32'h0);
                        chk("rnd_err_wait", 32'(o_m_err), 32'h0);
                        chk("rnd_s_cyc", 32'(o_s_cyc), (tgt[w] >= 0) ? 32'(1 << tgt[w]) : 32'h0);
                    end else if (tgt[w] < 0) begin
                        chk("rnd_miss_err", 32'(o_m_err), 32'(1 << w));
                        chk("rnd_miss_ack", 32'(o_m_ack), 32'h0);
                        chk("rnd_miss_to", 32'(o_timeout), 32'h0);
                    end else if (lat[w] + 1 <= TO) begin
                        chk("rnd_ack", 32'(o_m_ack), 32'(1 << w));
                        chk("rnd_dat", o_m_dat, s_dat[tgt[w]*DW +: DW]);
                        chk("rnd_ack_err", 32'(o_m_err), 32'h0);
                        chk("rnd_ack_to", 32'(o_timeout), 32'h0);
                    end else begin
                        chk("rnd_to_err", 32'(o_m_err), 32'(1 << w));
                        chk("rnd_to_pulse", 32'(o_timeout), 32'h1);
                        chk("rnd_to_ack", 32'(o_m_ack), 32'h0);
                        chk("rnd_to_stb", 32'(o_s_stb), 32'h0);
                    end
                end
                tick();
                m_cyc[w] = 1'b0;
                m_stb[w] = 1'b0;
                s_ack = '0;
                tick();
                req[w] = 1'b0;
                last = w;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
